can_tx_mailbox_scheduler: RTL

- Shares the single CAN transmit path (controller + packetizer) between NUM_MB host TX mailboxes.
- Picks the pending mailbox with the highest CAN priority (lowest identifier), loads its ID into the packetizer and starts the controller.
- Interprets the controller's 3-bit status code: retries on arbitration loss or ACK error, and reports done or abort per mailbox.
- Sits between the host register file and the CAN controller; drives the controller's send-request input.

---
 rtl/can_tx_mailbox_scheduler.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/can_tx_mailbox_scheduler.sv
// can_tx_mailbox_scheduler
// Shares one CAN transmit path between NUM_MB host TX mailboxes. The pending
// mailbox with the lowest CAN arbitration key is loaded into the packetizer
// and the controller is asked to send it; the controller's status code
// decides between done, retry (with re-arbitration) and abort.
// Optional build macro: CAN_TX_SCHED_TIMEOUT_EN adds a SEND watchdog of
// TIMEOUT_CYC clocks that aborts a frame whose status never arrives.
//
// Handshake with the controller: o_tx_send is a level request held for the
// whole attempt; the controller answers with a single-cycle i_tx_sts_valid
// strobe carrying i_tx_sts_code, and o_tx_send drops in the following cycle.
// o_pkt_load is a single-cycle strobe with o_pkt_id/o_pkt_ide already stable.
module can_tx_mailbox_scheduler #(
    parameter int NUM_MB      = 4,
    parameter int MAX_RETRY   = 7,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 i_sched_clk,
    input  logic                 i_sched_rst_n,
    input  logic [NUM_MB-1:0]    i_mb_req,
    input  logic [NUM_MB-1:0]    i_mb_abort,
    input  logic [NUM_MB*29-1:0] i_mb_id,
    input  logic [NUM_MB-1:0]    i_mb_ide,
    input  logic                 i_tx_sts_valid,
    input  logic [2:0]           i_tx_sts_code,
    output logic                 o_tx_send,
    output logic                 o_pkt_load,
    output logic [28:0]          o_pkt_id,
    output logic                 o_pkt_ide,
    output logic [2:0]           o_sel_idx,
    output logic                 o_busy,
    output logic [NUM_MB-1:0]    o_mb_done,
    output logic [NUM_MB-1:0]    o_mb_aborted,
    output logic [3:0]           o_retry_cnt,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NUM_MB-1:0]   blocked;
    logic                abort_pend;
    logic                abort_pend_nxt;
    logic [3:0]          retry_nxt;
    logic [3:0]          retry_inc;
    logic [NUM_MB-1:0]   done_nxt;
    logic [NUM_MB-1:0]   abrt_nxt;
    logic                load_sel;

    logic [NUM_MB-1:0]   cand;
    logic [NUM_MB-1:0]   sel_mask;
    logic                active;
    logic                abort_sel;
    logic                timeout_hit;

    logic                win_found;
    logic [2:0]          win_idx;
    logic [29:0]         win_key;
    logic [28:0]         win_id;
    logic                win_ide;

    // Arbitration key: base ID, then IDE (standard beats extended on equal
    // base), then extension bits (zero for standard frames).
    function automatic logic [29:0] prio_key(input logic [28:0] id, input logic ide);
        prio_key = {id[28:18], ide, ide ? id[17:0] : 18'h0};
    endfunction

    // Candidates exclude blocked mailboxes and any being aborted this cycle.
    assign cand = i_mb_req & ~blocked & ~i_mb_abort;

    // Lowest key wins; strict compare keeps the lower index on a tie.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_key   = '1;
        win_id    = '0;
        win_ide   = 1'b0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (cand[i] && (!win_found ||
                            prio_key(i_mb_id[i*29 +: 29], i_mb_ide[i]) < win_key)) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_key   = prio_key(i_mb_id[i*29 +: 29], i_mb_ide[i]);
                win_id    = i_mb_id[i*29 +: 29];
                win_ide   = i_mb_ide[i];
            end
        end
    end

    // One-hot view of the latched mailbox index.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            sel_mask[i] = (o_sel_idx == 3'(i));
        end
    end

    assign active    = (state == ST_LOAD) || (state == ST_SEND);
    assign abort_sel = |(i_mb_abort & sel_mask);
    assign retry_inc = (o_retry_cnt == 4'hF) ? 4'hF : o_retry_cnt + 4'd1;

`ifdef CAN_TX_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog runs only while in SEND; it is held at zero otherwise, so it
    // starts from zero on every entry to SEND.
    always_ff @(posedge i_sched_clk or negedge i_sched_rst_n) begin
        if (!i_sched_rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_SEND) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_hit = (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and pulse decode.
    always_comb begin
        state_nxt      = state;
        retry_nxt      = o_retry_cnt;
        abort_pend_nxt = abort_pend;
        done_nxt       = '0;
        load_sel       = 1'b0;
        // Host aborts of any mailbox not currently on the bus act at once.
        abrt_nxt       = i_mb_abort & ~(active ? sel_mask : {NUM_MB{1'b0}});
        if (active && abort_sel) begin
            abort_pend_nxt = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                retry_nxt      = '0;
                abort_pend_nxt = 1'b0;
                if (|(i_mb_req & ~blocked)) begin
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                abort_pend_nxt = 1'b0;
                if (win_found) begin
                    load_sel  = 1'b1;
                    state_nxt = ST_LOAD;
                    // The retry count belongs to a frame, not to the scheduler.
                    if (win_idx != o_sel_idx) begin
                        retry_nxt = '0;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_sts_valid) begin
                    if (i_tx_sts_code == 3'd3) begin
                        done_nxt  = sel_mask;
                        retry_nxt = '0;
                        state_nxt = ST_IDLE;
                    end else if (abort_pend || abort_sel) begin
                        abrt_nxt  = abrt_nxt | sel_mask;
                        state_nxt = ST_IDLE;
                    end else begin
                        // The final count stays visible alongside the aborted
                        // pulse; IDLE clears it on the following clock.
                        retry_nxt = retry_inc;
                        if (retry_inc >= 4'(MAX_RETRY)) begin
                            abrt_nxt  = abrt_nxt | sel_mask;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_SELECT;
                        end
                    end
                end else if (timeout_hit) begin
                    abrt_nxt  = abrt_nxt | sel_mask;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered pulse outputs.
    always_ff @(posedge i_sched_clk or negedge i_sched_rst_n) begin
        if (!i_sched_rst_n) begin
            state        <= ST_IDLE;
            blocked      <= '0;
            abort_pend   <= 1'b0;
            o_retry_cnt  <= '0;
            o_mb_done    <= '0;
            o_mb_aborted <= '0;
            o_sel_idx    <= '0;
            o_pkt_id     <= '0;
            o_pkt_ide    <= 1'b0;
        end else begin
            state        <= state_nxt;
            // A finished mailbox stays blocked until the host drops its request.
            blocked      <= (blocked | done_nxt | abrt_nxt) & i_mb_req;
            abort_pend   <= abort_pend_nxt;
            o_retry_cnt  <= retry_nxt;
            o_mb_done    <= done_nxt;
            o_mb_aborted <= abrt_nxt;
            if (load_sel) begin
                o_sel_idx <= win_idx;
                o_pkt_id  <= win_id;
                o_pkt_ide <= win_ide;
            end
        end
    end

    assign o_tx_send   = (state == ST_SEND);
    assign o_pkt_load  = (state == ST_LOAD);
    assign o_busy      = (state != ST_IDLE);
    assign o_dbg_state = state;

endmodule
